full_adder: RTL and testbench



---
 rtl/full_adder_if.sv | 25 ++
 rtl/full_adder.sv | 69 ++++++
 tb/tb_full_adder.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/full_adder_if.sv
// Operand/result bundle for the registered add-with-carry block.
// Valid-only handshake: in_valid qualifies a/b/c_in at a rising edge, and out_valid marks a fresh result one cycle later; there is no ready and no backpressure.
interface full_adder_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic             in_valid;
  logic [WIDTH-1:0] sum;
  logic             c_out;
  logic             ovf;
  logic             zero;
  logic             out_valid;

  modport master (
    output a, b, c_in, in_valid,
    input  sum, c_out, ovf, zero, out_valid
  );

  modport slave (
    input  a, b, c_in, in_valid,
    output sum, c_out, ovf, zero, out_valid
  );
endinterface

// File: rtl/full_adder.sv
// Registered WIDTH-bit adder with carry-in/carry-out, overflow and zero flags.
// Carries are formed by CLA_GROUP-bit lookahead blocks that ripple between each other.
module full_adder #(
  parameter int WIDTH     = 4,
  parameter int CLA_GROUP = 4
) (
  input logic        clk,
  input logic        rst,
  full_adder_if.slave bus
);

  localparam int NUM_GROUPS = WIDTH / CLA_GROUP;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] sum_next;
  logic             c_out_next;
  logic             ovf_next;
  logic             zero_next;

  assign gen  = bus.a & bus.b;
  assign prop = bus.a ^ bus.b;

  // Inside a group every carry is derived from the group carry-in through
  // running generate/propagate prefixes, so only group boundaries ripple.
  always_comb begin
    logic grp_g;
    logic grp_p;
    carry    = '0;
    grp_g    = 1'b0;
    grp_p    = 1'b1;
    carry[0] = bus.c_in;
    for (int gi = 0; gi < NUM_GROUPS; gi++) begin
      grp_g = 1'b0;
      grp_p = 1'b1;
      for (int j = 0; j < CLA_GROUP; j++) begin
        grp_g = gen[gi*CLA_GROUP + j] | (prop[gi*CLA_GROUP + j] & grp_g);
        grp_p = grp_p & prop[gi*CLA_GROUP + j];
        carry[gi*CLA_GROUP + j + 1] = grp_g | (grp_p & carry[gi*CLA_GROUP]);
      end
    end
  end

  assign sum_next   = prop ^ carry[WIDTH-1:0];
  assign c_out_next = carry[WIDTH];
  assign ovf_next   = carry[WIDTH] ^ carry[WIDTH-1];
  assign zero_next  = ~|sum_next;

  // Flags hold across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.sum       <= '0;
      bus.c_out     <= 1'b0;
      bus.ovf       <= 1'b0;
      bus.zero      <= 1'b0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.sum   <= sum_next;
        bus.c_out <= c_out_next;
        bus.ovf   <= ovf_next;
        bus.zero  <= zero_next;
      end
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// Bench for full_adder: five configurations driven in lockstep, each checked
// every cycle against an arithmetic model through a per-DUT expected queue.
module tb_full_adder;

  localparam int NDUT = 5;
  localparam int WIDTHS [NDUT] = '{4, 4, 4, 8, 32};

  logic clk;
  logic rst;

  full_adder_if #(.WIDTH(4))  bus0 ();
  full_adder_if #(.WIDTH(4))  bus1 ();
  full_adder_if #(.WIDTH(4))  bus2 ();
  full_adder_if #(.WIDTH(8))  bus3 ();
  full_adder_if #(.WIDTH(32)) bus4 ();

  full_adder #(.WIDTH(4),  .CLA_GROUP(4)) dut0 (.clk(clk), .rst(rst), .bus(bus0));
  full_adder #(.WIDTH(4),  .CLA_GROUP(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
  full_adder #(.WIDTH(4),  .CLA_GROUP(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  full_adder #(.WIDTH(8),  .CLA_GROUP(4)) dut3 (.clk(clk), .rst(rst), .bus(bus3));
  full_adder #(.WIDTH(32), .CLA_GROUP(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run;
  int tests_failed;
  int cycle_no;

  // entry layout: {out_valid, zero, ovf, c_out, sum[31:0]}
  logic [35:0] exp_q [NDUT][$];
  logic [34:0] last_res [NDUT];

  // independent model: wide addition, overflow from operand/result signs
  function automatic logic [34:0] model(input int w, input logic [31:0] a,
                                        input logic [31:0] b, input logic cin);
    logic [32:0] mask;
    logic [32:0] full;
    logic [31:0] s;
    logic        co;
    logic        ov;
    logic        z;
    mask = (33'd1 << w) - 33'd1;
    full = ({1'b0, a} & mask) + ({1'b0, b} & mask) + {32'd0, cin};
    s    = full[31:0] & mask[31:0];
    co   = full[w];
    ov   = (a[w-1] == b[w-1]) && (s[w-1] != a[w-1]);
    z    = (s == 32'd0);
    return {z, ov, co, s};
  endfunction

  // driver: apply one vector to every DUT and queue what each must show next
  task automatic drive(input logic [31:0] a, input logic [31:0] b,
                       input logic cin, input logic v, input logic r);
    bus0.a = a[3:0];  bus0.b = b[3:0];  bus0.c_in = cin; bus0.in_valid = v;
    bus1.a = a[3:0];  bus1.b = b[3:0];  bus1.c_in = cin; bus1.in_valid = v;
    bus2.a = a[3:0];  bus2.b = b[3:0];  bus2.c_in = cin; bus2.in_valid = v;
    bus3.a = a[7:0];  bus3.b = b[7:0];  bus3.c_in = cin; bus3.in_valid = v;
    bus4.a = a;       bus4.b = b;       bus4.c_in = cin; bus4.in_valid = v;
    rst = r;
    for (int k = 0; k < NDUT; k++) begin
      if (r) begin
        last_res[k] = '0;
        exp_q[k].push_back(36'd0);
      end else if (v) begin
        last_res[k] = model(WIDTHS[k], a, b, cin);
        exp_q[k].push_back({1'b1, last_res[k]});
      end else begin
        exp_q[k].push_back({1'b0, last_res[k]});
      end
    end
  endtask

  // scoreboard: advance one edge, pop and compare every DUT
  task automatic cycle(input string tag);
    logic [35:0] obs [NDUT];
    logic [35:0] exp_v;
    @(posedge clk);
    #1;
    cycle_no++;
    obs[0] = {bus0.out_valid, bus0.zero, bus0.ovf, bus0.c_out, 28'd0, bus0.sum};
    obs[1] = {bus1.out_valid, bus1.zero, bus1.ovf, bus1.c_out, 28'd0, bus1.sum};
    obs[2] = {bus2.out_valid, bus2.zero, bus2.ovf, bus2.c_out, 28'd0, bus2.sum};
    obs[3] = {bus3.out_valid, bus3.zero, bus3.ovf, bus3.c_out, 24'd0, bus3.sum};
    obs[4] = {bus4.out_valid, bus4.zero, bus4.ovf, bus4.c_out, bus4.sum};
    for (int k = 0; k < NDUT; k++) begin
      tests_run++;
      if (exp_q[k].size() == 0) begin
        tests_failed++;
        $error("FAIL %s dut%0d cycle %0d: got %h, expected queue empty", tag, k, cycle_no, obs[k]);
      end else begin
        exp_v = exp_q[k].pop_front();
        assert (obs[k] === exp_v) else begin
          tests_failed++;
          $error("FAIL %s dut%0d cycle %0d: got {v,z,o,c,sum}=%h expected %h",
                 tag, k, cycle_no, obs[k], exp_v);
        end
      end
    end
  endtask

  // fixed expectations on the 4-bit lookahead DUT
  task automatic expect4(input string tag, input logic [3:0] s, input logic co,
                         input logic ov, input logic z, input logic vld);
    logic [7:0] got;
    logic [7:0] want;
    got  = {bus0.out_valid, bus0.zero, bus0.ovf, bus0.c_out, bus0.sum};
    want = {vld, z, ov, co, s};
    tests_run++;
    assert (got === want) else begin
      tests_failed++;
      $error("FAIL %s const: got {v,z,o,c,sum}=%h expected %h", tag, got, want);
    end
  endtask

  initial begin
    logic v;
    tests_run    = 0;
    tests_failed = 0;
    cycle_no     = 0;
    for (int k = 0; k < NDUT; k++) last_res[k] = '0;

    // reset held two cycles with random operands
    drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    cycle("reset1");
    drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b1);
    cycle("reset2");
    expect4("reset", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(32'h0, 32'h0, 1'b0, 1'b1, 1'b0);
    cycle("zero");
    expect4("zero", 4'h0, 1'b0, 1'b0, 1'b1, 1'b1);

    drive(32'hF, 32'h1, 1'b0, 1'b1, 1'b0);
    cycle("wrap_f_1");
    expect4("wrap_f_1", 4'h0, 1'b1, 1'b0, 1'b1, 1'b1);

    drive(32'hF, 32'hF, 1'b1, 1'b1, 1'b0);
    cycle("wrap_f_f_1");
    expect4("wrap_f_f_1", 4'hF, 1'b1, 1'b0, 1'b0, 1'b1);

    drive(32'h7, 32'h1, 1'b0, 1'b1, 1'b0);
    cycle("ovf_7_1");
    expect4("ovf_7_1", 4'h8, 1'b0, 1'b1, 1'b0, 1'b1);

    drive(32'h8, 32'h8, 1'b0, 1'b1, 1'b0);
    cycle("ovf_8_8");
    expect4("ovf_8_8", 4'h0, 1'b1, 1'b1, 1'b1, 1'b1);

    drive(32'h5, 32'h6, 1'b1, 1'b0, 1'b0);
    cycle("hold");
    expect4("hold", 4'h0, 1'b1, 1'b1, 1'b1, 1'b0);

    drive(32'h3, 32'h4, 1'b0, 1'b1, 1'b1);
    cycle("rst_over_valid");
    expect4("rst_over_valid", 4'h0, 1'b0, 1'b0, 1'b0, 1'b0);

    drive(32'h2, 32'h2, 1'b0, 1'b1, 1'b0);
    cycle("after_reset");
    expect4("after_reset", 4'h4, 1'b0, 1'b0, 1'b0, 1'b1);

    // back-to-back random vectors
    for (int i = 0; i < 1100; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b1, 1'b0);
      cycle("rand");
    end

    // random idle gaps and an occasional mid-stream reset
    for (int i = 0; i < 200; i++) begin
      v = ($urandom_range(0, 3) != 0);
      drive($urandom, $urandom, 1'($urandom_range(0, 1)), v,
            1'($urandom_range(0, 31) == 0));
      cycle("rand_mix");
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
